// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, the err_code values and the default memory depth.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    localparam int DEPTH_DEFAULT = 256;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive bytes into a little-endian 32-bit word.
// vld_p1 pulses for one cycle, with word_p1 held, after the 4th byte is taken.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        vld_p1,
    output logic [31:0] word_p1
);

    logic [1:0]  cnt;
    logic [23:0] partial;

    assign last_byte = (cnt == 2'd3);

    // Stage p1: completed word and its strobe; earlier bytes shift down from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            partial <= 24'd0;
            word_p1 <= 32'd0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (clear) begin
                cnt <= 2'd0;
            end else if (byte_valid) begin
                cnt <= cnt + 2'd1;
                if (last_byte) begin
                    word_p1 <= {byte_in, partial};
                    vld_p1  <= 1'b1;
                end else begin
                    partial <= {byte_in, partial[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// while holding the CPU in reset until a load completes cleanly.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = DEPTH_DEFAULT,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_nxt;
    logic        accept;
    logic        start_ok;
    logic        last_byte;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic        len_too_big;
    logic [15:0] widx;
    logic [7:0]  csum;

    assign accept      = rx_valid && rx_ready;
    assign start_ok    = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    assign len_full    = {rx_data, len_lo};
    assign len_too_big = {1'b0, len_full} > DEPTH_L;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start && start_ok),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_in    (rx_data),
        .last_byte  (last_byte),
        .vld_p1     (mem_we),
        .word_p1    (mem_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (load_start) state_nxt = ST_LEN_LO;
            end
            ST_DONE: begin
                cpu_hold = 1'b0;
                if (load_start) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (len_too_big)          state_nxt = ST_ERROR;
                    else if (len_full == '0)  state_nxt = ST_CHECK;
                    else                      state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                // widx still names the word being completed: its write lands a cycle later.
                if (accept && last_byte && (widx == len - 16'd1)) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERROR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo   <= 8'd0;
            len      <= 16'd0;
            widx     <= 16'd0;
            csum     <= 8'd0;
            mem_addr <= ADDR_BASE;
            done     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (load_start && start_ok) begin
                widx     <= 16'd0;
                csum     <= 8'd0;
                mem_addr <= ADDR_BASE;
                done     <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (mem_we) widx <= widx + 16'd1;
            if (accept) begin
                case (state)
                    ST_LEN_LO: len_lo <= rx_data;
                    ST_LEN_HI: begin
                        len <= len_full;
                        if (len_too_big) err_code <= ERR_LEN;
                    end
                    ST_DATA: begin
                        csum <= csum ^ rx_data;
                        if (last_byte) mem_addr <= ADDR_BASE + {14'd0, widx, 2'b00};
                    end
                    ST_CHECK: begin
                        if (rx_data == csum) done     <= 1'b1;
                        else                 err_code <= ERR_CSUM;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-stream reference model checks every cycle,
// and directed loads pin the model against hand-computed results.
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    imem_loader #(.DEPTH(DEPTH), .ADDR_BASE(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks position in the stream of the current load.
    bit          m_ready = 0;
    bit          m_done  = 0;
    int          m_err   = 0;
    int          m_pos   = 0;
    int          m_n     = 0;
    logic [7:0]  m_lo;
    logic [7:0]  m_csum;
    logic [31:0] m_word;
    bit          exp_we = 0;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ready = 0; m_done = 0; m_err = 0; exp_we = 0;
            chk("rst_rx_ready", 32'(rx_ready), 32'd0);
            chk("rst_mem_we",   32'(mem_we),   32'd0);
            chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
            chk("rst_busy",     32'(busy),     32'd0);
            chk("rst_done",     32'(done),     32'd0);
            chk("rst_err",      32'(err_code), 32'd0);
            chk("rst_addr",     mem_addr,      32'd0);
            chk("rst_wdata",    mem_wdata,     32'd0);
        end else begin
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            if (mem_we && exp_we) begin
                chk("mem_addr",  mem_addr,  exp_addr);
                chk("mem_wdata", mem_wdata, exp_data);
            end
            chk("rx_ready", 32'(rx_ready), 32'(m_ready));
            chk("busy",     32'(busy),     32'(m_ready));
            chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
            chk("done",     32'(done),     32'(m_done));
            chk("err_code", 32'(err_code), 32'(m_err));
            exp_we = 0;
            if (load_start && !m_ready) begin
                m_ready = 1; m_done = 0; m_err = 0; m_pos = 0; m_csum = 8'h00;
            end else if (rx_valid && m_ready) begin
                if (m_pos == 0) begin
                    m_lo = rx_data;
                end else if (m_pos == 1) begin
                    m_n = int'({rx_data, m_lo});
                    if (m_n > DEPTH) begin
                        m_ready = 0; m_err = 1;
                    end
                end else if (m_pos < 2 + 4 * m_n) begin
                    m_word[8 * ((m_pos - 2) % 4) +: 8] = rx_data;
                    m_csum = m_csum ^ rx_data;
                    if ((m_pos - 2) % 4 == 3) begin
                        exp_we   = 1;
                        exp_addr = 32'(4 * ((m_pos - 2) / 4));
                        exp_data = m_word;
                    end
                end else begin
                    m_ready = 0;
                    if (rx_data == m_csum) m_done = 1;
                    else                   m_err  = 2;
                end
                m_pos++;
            end
        end
    end

    logic [7:0] tx[$];

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load();
        wr_addr.delete();
        wr_data.delete();
        load_start = 1'b1;
        cycles(1);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit hs;
        int budget;
        if (gaps && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            cycles($urandom_range(1, 3));
        end
        rx_data  = b;
        rx_valid = 1'b1;
        hs       = 1'b0;
        budget   = 0;
        while (!hs && budget < 200) begin
            @(negedge clk);
            hs = rx_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!hs) begin
            n_fail++;
            $display("FAIL send_timeout: byte 0x%02h not accepted within %0d cycles", b, budget);
        end
        rx_valid = 1'b0;
    endtask

    task automatic play(input bit gaps, input bit pulses);
        foreach (tx[i]) begin
            if (pulses && i > 5 && $urandom_range(0, 15) == 0) load_start = 1'b1;
            send_byte(tx[i], gaps);
            load_start = 1'b0;
        end
        cycles(3);
    endtask

    task automatic build(input int n, input bit bad);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        tx.delete();
        tx.push_back(8'(n));
        tx.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs = cs ^ b;
            tx.push_back(b);
        end
        tx.push_back(bad ? cs ^ 8'($urandom_range(1, 255)) : cs);
    endtask

    task automatic literal_stream(input logic [7:0] ck);
        tx = '{8'h02, 8'h00, 8'h37, 8'h04, 8'h01, 8'h10, 8'h83, 8'h24, 8'h44, 8'h00, ck};
    endtask

    function automatic logic [31:0] wr_at(input int i, input bit want_data);
        if (wr_addr.size() <= i) return 32'hDEAD_BEEF;
        return want_data ? wr_data[i] : wr_addr[i];
    endfunction

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Known two-word program with a correct checksum.
        start_load();
        literal_stream(8'hC1);
        play(0, 0);
        chk("lit_nwr",   32'(wr_addr.size()), 32'd2);
        chk("lit_a0",    wr_at(0, 0), 32'h0000_0000);
        chk("lit_d0",    wr_at(0, 1), 32'h1001_0437);
        chk("lit_a1",    wr_at(1, 0), 32'h0000_0004);
        chk("lit_d1",    wr_at(1, 1), 32'h0044_2483);
        chk("lit_done",  32'(done),     32'd1);
        chk("lit_hold",  32'(cpu_hold), 32'd0);

        start_load();
        literal_stream(8'h00);
        play(0, 0);
        chk("bad_nwr",  32'(wr_addr.size()), 32'd2);
        chk("bad_err",  32'(err_code), 32'd2);
        chk("bad_done", 32'(done),     32'd0);
        chk("bad_hold", 32'(cpu_hold), 32'd1);

        start_load();
        tx = '{8'h01, 8'h01};
        play(0, 0);
        chk("big_err",   32'(err_code), 32'd1);
        chk("big_nwr",   32'(wr_addr.size()), 32'd0);
        chk("big_ready", 32'(rx_ready), 32'd0);

        start_load();
        tx = '{8'h00, 8'h00, 8'h00};
        play(0, 0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_nwr",  32'(wr_addr.size()), 32'd0);
        start_load();
        tx = '{8'h00, 8'h00, 8'h5A};
        play(1, 0);
        chk("zero_bad_err", 32'(err_code), 32'd2);

        // Reset in the middle of the second word.
        start_load();
        tx = '{8'h02, 8'h00, 8'h37, 8'h04, 8'h01, 8'h10, 8'h83, 8'h24};
        foreach (tx[i]) send_byte(tx[i], 0);
        rst_n = 1'b0;
        #2;
        chk("abort_hold",  32'(cpu_hold), 32'd1);
        chk("abort_ready", 32'(rx_ready), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        chk("abort_nwr",   32'(wr_addr.size()), 32'd1);
        chk("abort_idle",  32'(rx_ready), 32'd0);
        start_load();
        literal_stream(8'hC1);
        play(0, 0);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_nwr",  32'(wr_addr.size()), 32'd2);

        for (int r = 0; r < 8; r++) begin
            int  n;
            bit  bad;
            n   = $urandom_range(0, 6);
            bad = ($urandom_range(0, 2) == 0);
            start_load();
            build(n, bad);
            play(1, 1);
            chk("rnd_done", 32'(done),     32'(!bad));
            chk("rnd_err",  32'(err_code), bad ? 32'd2 : 32'd0);
            chk("rnd_nwr",  32'(wr_addr.size()), 32'(n));
        end

        // Full-depth load with gaps and ignored load_start pulses.
        start_load();
        build(DEPTH, 0);
        play(1, 1);
        chk("full_done",  32'(done), 32'd1);
        chk("full_nwr",   32'(wr_addr.size()), 32'(DEPTH));
        chk("full_last",  wr_at(DEPTH - 1, 0), 32'h0000_03FC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_start  input  1  one-cycle pulse requesting a new program load.
REQ-006 rx_data  input  8  incoming stream byte.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr  output  32  byte address of the write, word-aligned.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  keeps the CPU/PC in reset while high.
REQ-013 busy  output  1  a load is in progress.
REQ-014 done  output  1  last load completed with a valid checksum.
REQ-015 err_code  output  2  0 none, 1 length too large, 2 checksum mismatch.

Function
REQ-016 Byte transfer SHALL occur only on cycles where rx_valid and rx_ready are both high.
REQ-017 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N data bytes, one checksum byte.
REQ-018 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
REQ-019 rx_ready SHALL be high in LEN_LO, LEN_HI, DATA and CHECK, and low in IDLE, DONE and ERROR.
REQ-020 load_start SHALL move IDLE, DONE or ERROR to LEN_LO, clear done and err_code, and reset the word index and checksum.
REQ-021 load_start in LEN_LO, LEN_HI, DATA or CHECK SHALL be ignored.
REQ-022 After LEN_HI is accepted: N > DEPTH -> ERROR with err_code=1 and no writes; N = 0 -> CHECK; otherwise -> DATA.
REQ-023 Data bytes SHALL be packed little-endian: the k-th byte of a word (k = 0..3) goes to bits [8k+7:8k].
REQ-024 mem_we SHALL pulse for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
REQ-025 mem_addr SHALL equal ADDR_BASE + 4*index, and mem_wdata SHALL hold the assembled word, both registered and valid while mem_we is high.
REQ-026 Word index SHALL increment after each write, from 0 to N-1; no wrap-around is possible given REQ-022.
REQ-027 DATA SHALL accept bytes back-to-back with no stall, including across word boundaries and during the mem_we cycle.
REQ-028 After word N-1's 4th byte is accepted, the FSM SHALL go to CHECK.
REQ-029 Checksum SHALL be the XOR of all data bytes (header excluded); with N = 0 the expected checksum is 8'h00.
REQ-030 In CHECK, an accepted byte equal to the checksum -> DONE with done=1; otherwise -> ERROR with err_code=2.
REQ-031 Memory written before a checksum failure SHALL NOT be rolled back.
REQ-032 cpu_hold SHALL be high in every state except DONE.
REQ-033 busy SHALL be high in LEN_LO, LEN_HI, DATA and CHECK.
REQ-034 rx_valid gaps SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, cpu_hold=1, rx_ready=0, mem_we=0, mem_addr=ADDR_BASE, mem_wdata=0, busy=0, done=0, err_code=0, and clear the index and checksum.
REQ-036 Reset asserted mid-load SHALL abort the load, issue no further writes, and require a new load_start.

Structure
REQ-037 Package imem_loader_pkg SHALL hold the FSM state enum, the err_code constants and the DEPTH default.
REQ-038 Sub-module byte_packer (byte counter plus 32-bit shift/assemble register, word_ready pulse) SHALL perform the byte-to-word assembly.

Verification
REQ-039 Reset then load_start, bytes 02 00 37 04 01 10 83 24 44 00 C1 -> writes (0x0, 0x10010437) and (0x4, 0x00442483), done=1, cpu_hold=0.
REQ-040 Same stream with checksum 0x00 -> both writes occur, err_code=2, done=0, cpu_hold=1.
REQ-041 Header 01 01 (N=257) -> ERROR with err_code=1, zero mem_we pulses, rx_ready=0.
REQ-042 Header 00 00 then 00 -> DONE with no writes; header 00 00 then 5A -> err_code=2.
REQ-043 rst_n low after 6 data bytes -> immediate IDLE, cpu_hold=1, only one write seen; a fresh load then succeeds.
REQ-044 load_start pulsed during DATA plus random rx_valid gaps -> load unaffected, 256-word load completes with last mem_addr=0x3FC.
